// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-stage PC control slice.
//   PC_W         : architectural PC width
//   RESET_PC_DEF : default PC loaded on reset
//   redirect_src_e : encoding reported on redirect_src_o
//   pc_state_e   : next-PC controller state
package mips_pkg;

    localparam int unsigned      PC_W         = 32;
    localparam logic [PC_W-1:0]  RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        RS_NONE   = 2'b00,
        RS_JUMP   = 2'b01,
        RS_BRANCH = 2'b10
    } redirect_src_e;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        BUBBLE = 2'b10
    } pc_state_e;

endpackage

// File: rtl/jump_target_gen.sv
// J/JAL target formation: {pc4[31:28], idx, 2'b00}.
//   pc4_i    in  32  PC+4 of the jump instruction
//   idx_i    in  26  instr[25:0] of the jump
//   target_o out 32  word-aligned jump target
module jump_target_gen
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] pc4_i,
    input  logic [25:0]     idx_i,
    output logic [PC_W-1:0] target_o
);

    // Only the region nibble of PC+4 contributes to the target.
    logic unused_pc4_low;
    assign unused_pc4_low = ^pc4_i[27:0];

    assign target_o = {pc4_i[31:28], idx_i, 2'b00};

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage next-PC controller: owns the PC, arbitrates between sequential
// fetch, ID jumps and EX taken branches, drives the squash signals and holds
// fetch invalid for IMEM_LAT cycles while instruction memory refills.
//   clk, rst_n        : clock, async active-low reset
//   stall_i           : hazard freeze of PC / IF
//   jump_req_i/idx/pc4: jump decoded in ID
//   br_req_i/target   : taken branch resolved in EX
//   pc_o, pc_plus4_o  : current fetch PC and PC+4
//   fetch_valid_o     : IF instruction valid
//   flush_ifid_o/idex : squash pipeline registers at next edge
//   redirect_src_o    : 00 none, 01 jump, 10 branch
//   misalign_o        : one-cycle pulse after a branch to an unaligned target
//   redirect_cnt_o    : saturating count of accepted redirects
module pc_redirect_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned IMEM_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             jump_req_i,
    input  logic [25:0]      jump_idx_i,
    input  logic [31:0]      jump_pc4_i,
    input  logic             br_req_i,
    input  logic [31:0]      br_target_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             fetch_valid_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic [1:0]       redirect_src_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    localparam logic [2:0] LAT = 3'(IMEM_LAT);

    pc_state_e        state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [2:0]       bub_q, bub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misalign_q, misalign_d;

    logic             active;
    logic             br_acc;
    logic             jmp_acc;
    logic [31:0]      jump_target;
    redirect_src_e    src;

    jump_target_gen u_jump_target_gen (
        .pc4_i    (jump_pc4_i),
        .idx_i    (jump_idx_i),
        .target_o (jump_target)
    );

    assign pc_plus4_o = pc_q + 32'd4;
    assign pc_o       = pc_q;

    // Requests are only honoured once the PC has left BOOT; a branch makes
    // the younger jump in ID irrelevant since IF/ID gets flushed anyway.
    assign active  = (state_q != BOOT);
    assign br_acc  = active && br_req_i;
    assign jmp_acc = active && jump_req_i && !br_req_i;

    always_comb begin
        src = RS_NONE;
        if (br_acc) begin
            src = RS_BRANCH;
        end else if (jmp_acc) begin
            src = RS_JUMP;
        end
    end

    assign flush_ifid_o   = br_acc || jmp_acc;
    assign flush_idex_o   = br_acc;
    assign redirect_src_o = src;
    assign fetch_valid_o  = (state_q == RUN);
    assign misalign_o     = misalign_q;
    assign redirect_cnt_o = cnt_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bub_d      = bub_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            default: begin
                if (br_acc || jmp_acc) begin
                    // Redirects win over stall_i and restart the refill window.
                    pc_d       = br_acc ? {br_target_i[31:2], 2'b00} : jump_target;
                    misalign_d = br_acc && (br_target_i[1:0] != 2'b00);
                    state_d    = BUBBLE;
                    bub_d      = LAT;
                    cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    if (!stall_i) begin
                        pc_d = pc_plus4_o;
                    end
                    // Refill time elapses independently of stalls.
                    if (state_q == BUBBLE) begin
                        bub_d = bub_q - 3'd1;
                        if (bub_q <= 3'd1) begin
                            state_d = RUN;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            bub_q      <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bub_q      <= bub_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Fetch-stage next-PC controller for the 5-stage MIPS pipeline. It owns the PC register and arbitrates between three sources:
- sequential PC+4;
- jump targets decoded in ID (26-bit index, shifted left 2, concatenated with PC+4[31:28]);
- taken-branch targets resolved in EX.

It squashes wrong-path instructions via flush outputs and inserts fetch bubbles while instruction memory refills after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)
IMEM_LAT, 1, fetch bubbles (fetch_valid_o low) after any redirect; legal range 1..7
CNT_W, 16, width of saturating redirect counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hazard unit freeze of PC / IF
jump_req_i  in  1  J/JAL decoded in ID this cycle
jump_idx_i  in  26  instr[25:0] of jump in ID
jump_pc4_i  in  32  PC+4 of jump instruction in ID
br_req_i  in  1  branch resolved taken in EX this cycle
br_target_i  in  32  branch target from EX
pc_o  out  32  current fetch PC
pc_plus4_o  out  32  pc_o + 4, modulo 2^32
fetch_valid_o  out  1  IF instruction is valid this cycle
flush_ifid_o  out  1  squash IF/ID at next edge
flush_idex_o  out  1  squash ID/EX at next edge
redirect_src_o  out  2  00 none, 01 jump, 10 branch (same cycle as flush)
misalign_o  out  1  one-cycle pulse: br_target_i[1:0] != 0 on accepted branch
redirect_cnt_o  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_PC, state=BOOT, bubble counter=0, redirect_cnt_o=0, misalign_o=0.
  - All flush outputs, fetch_valid_o and redirect_src_o read 0.
- States BOOT, RUN, BUBBLE. Registered state; flush_*, redirect_src_o and fetch_valid_o are combinational from state plus requests.
- BOOT: fetch_valid_o=0 for exactly one cycle, PC held, then → RUN. Requests in BOOT are ignored.
- Priority each cycle in RUN or BUBBLE: br_req_i > jump_req_i > stall_i > sequential.
- Branch accepted:
  - flush_ifid_o=1, flush_idex_o=1, redirect_src_o=10.
  - Next edge: pc_o <= {br_target_i[31:2],2'b00}.
  - If br_target_i[1:0]!=0, misalign_o=1 the following cycle only.
- Jump accepted (no branch):
  - flush_ifid_o=1, flush_idex_o=0, redirect_src_o=01.
  - Next edge: pc_o <= {jump_pc4_i[31:28], jump_idx_i, 2'b00}.
- Simultaneous branch and jump: branch wins and the jump is dropped, since the jump is younger and squashed by flush_ifid_o.
- Redirect overrides stall_i: the PC loads even when stall_i=1.
- Any redirect: state → BUBBLE, bubble counter <= IMEM_LAT, redirect_cnt_o increments and saturates at all-ones.
- BUBBLE:
  - fetch_valid_o=0; PC advances by +4 each non-stalled cycle.
  - Counter decrements every cycle regardless of stall_i; at 1 → RUN.
  - A redirect in BUBBLE is accepted and reloads the counter to IMEM_LAT.
- RUN with no redirect:
  - stall_i=1: pc_o held, fetch_valid_o=1.
  - Otherwise pc_o <= pc_plus4_o; 32'hFFFF_FFFC wraps to 0.
- Reset asserted mid-BUBBLE or during a redirect cycle: immediate return to reset values; the pending redirect is lost.

Decomposition:
- Shared package mips_pkg holds:
  - PC_W=32, RESET_PC default;
  - redirect_src encodings (RS_NONE/RS_JUMP/RS_BRANCH);
  - state enum (BOOT/RUN/BUBBLE).
- One natural sub-module: jump_target_gen (combinational {pc4[31:28], idx, 2'b00}).
- Arbitration, FSM and counters stay in the top module.

Test Plan:
- Reset, then release; hold all requests 0 → cycle 1 fetch_valid_o=0, pc_o=0; cycle 2 fetch_valid_o=1, pc_o=0; then pc_o=4, 8, 12.
- In RUN, jump_req_i=1, jump_pc4_i=32'h0040_0010, jump_idx_i=26'h000_0100:
  - same cycle: flush_ifid_o=1, redirect_src_o=01, flush_idex_o=0;
  - next: pc_o=32'h0000_0400, fetch_valid_o=0 for 1 cycle, redirect_cnt_o=1.
- Same cycle br_req_i=1 with br_target_i=32'h0000_2000 and jump_req_i=1 → flush_ifid_o=flush_idex_o=1, redirect_src_o=10, next pc_o=32'h0000_2000, jump ignored.
- stall_i=1 for 3 cycles at pc_o=32'h0000_0020 → pc_o constant; branch to 32'h0000_0100 during stall → loaded next edge.
- br_target_i=32'h0000_0103 → pc_o=32'h0000_0100, misalign_o pulses one cycle.
- pc_o=32'hFFFF_FFFC, no stall → next pc_o=0; IMEM_LAT=3: branch in 2nd bubble cycle restarts 3 bubbles; rst_n low mid-bubble → pc_o=RESET_PC immediately.
